// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register map,
// STAT/CON bit positions and the transmitter state encoding.
package uart_pkg;

  localparam logic [31:0] OFS_TXD  = 32'h0;
  localparam logic [31:0] OFS_STAT = 32'h4;
  localparam logic [31:0] OFS_CON  = 32'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

  localparam int CON_IRQ_EN = 0;
  localparam int CON_DONE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic logic [31:0] pack_stat(input logic busy, input logic full,
                                            input logic empty, input logic ovf,
                                            input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]  = busy;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Small synchronous FIFO. The head entry is read combinationally so the
// transmitter can load it on the same edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXD/STAT/CON registers, byte FIFO,
// 8N1 serializer and a level transmit-done interrupt.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
  parameter int          CLK_DIV    = 10416,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  logic             sel_txd, sel_stat, sel_con;
  logic             txd_wr, con_wr;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  tx_state_e        state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg;
  logic             baud_end;
  logic             done_set;

  logic             done_reg, done_next;
  logic             ovf_reg, ovf_next;
  logic             irq_en_reg, irq_en_next;
  logic             irq_reg;
  logic [7:0]       last_byte_reg;

  assign sel_txd  = (addr == BASE_ADDR + OFS_TXD);
  assign sel_stat = (addr == BASE_ADDR + OFS_STAT);
  assign sel_con  = (addr == BASE_ADDR + OFS_CON);
  assign txd_wr   = wr && sel_txd;
  assign con_wr   = wr && sel_con;

  assign baud_end = (baud_cnt_reg == BAUD_LAST);
  // The FIFO is drained when idle, or at the end of a stop bit for back-to-back frames.
  assign fifo_pop = !fifo_empty &&
                    ((state_reg == ST_IDLE) || (state_reg == ST_STOP && baud_end));
  assign done_set = (state_reg == ST_STOP) && baud_end && fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txd_wr),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_reg    <= ST_START;
            shift_reg    <= fifo_head;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            state_reg    <= ST_DATA;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (!fifo_empty) begin
              state_reg <= ST_START;
              shift_reg <= fifo_head;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  // Setting events win over a simultaneous write-1-to-clear.
  always_comb begin
    done_next   = done_reg;
    ovf_next    = ovf_reg;
    irq_en_next = irq_en_reg;
    if (con_wr) begin
      irq_en_next = wdata[CON_IRQ_EN];
      if (wdata[CON_DONE]) begin
        done_next = 1'b0;
        ovf_next  = 1'b0;
      end
    end
    if (done_set) begin
      done_next = 1'b1;
    end
    if (txd_wr && fifo_full && !fifo_pop) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      irq_en_reg    <= 1'b0;
      irq_reg       <= 1'b0;
      last_byte_reg <= '0;
    end else begin
      done_reg   <= done_next;
      ovf_reg    <= ovf_next;
      irq_en_reg <= irq_en_next;
      irq_reg    <= done_next & irq_en_next;
      if (txd_wr && (!fifo_full || fifo_pop)) begin
        last_byte_reg <= wdata[7:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd) begin
        rdata = {24'h0, last_byte_reg};
      end else if (sel_stat) begin
        rdata = pack_stat(state_reg != ST_IDLE, fifo_full, fifo_empty, ovf_reg,
                          STAT_CNT_W'(fifo_count));
      end else if (sel_con) begin
        rdata[CON_IRQ_EN] = irq_en_reg;
        rdata[CON_DONE]   = done_reg;
      end
    end
  end

  assign tx  = tx_reg;
  assign irq = irq_reg;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: queued bytes are compared against
// frames decoded from the serial line, plus register/timing checks.
module tb_uart_tx_periph;

  localparam logic [31:0] BASE = 32'h4000_0020;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STAT = BASE + 32'h4;
  localparam logic [31:0] CON  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  logic mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int start_q[$];

  uart_tx_periph #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1;
    addr = a;
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    bus_write(TXD, {24'h0, b});
  endtask

  task automatic wait_idle(input string tag, input int bound);
    logic [31:0] s;
    s = 32'h1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      bus_read(STAT, s);
      if (!s[0]) break;
    end
    check_val(tag, {31'b0, s[0]}, 32'h0);
  endtask

  // Frame decoder: samples each bit mid-cell and pops the scoreboard.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (7) @(negedge clk);
        check_val("start_bit", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          d[i] = tx;
        end
        repeat (16) @(negedge clk);
        check_val("stop_bit", {31'b0, tx}, 32'h1);
        frames++;
        $display("frame %0d at cycle %0d: data 0x%02h", frames, start_q[$], d);
        if (exp_q.size() == 0) check_val("unexpected_frame", {24'h0, d}, 32'h100);
        else check_val("frame_data", {24'h0, d}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] r;
    int c0, nb, n, lows;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and address decode
    check_val("rst_tx", {31'b0, tx}, 32'h1);
    check_val("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(STAT, r); check_val("rst_stat", r, 32'h4);
    bus_read(CON, r);  check_val("rst_con", r, 32'h0);
    bus_read(TXD, r);  check_val("rst_txd", r, 32'h0);
    bus_read(BASE + 32'hC, r); check_val("rd_unmapped_c", r, 32'h0);
    bus_read(32'h4000_0000, r); check_val("rd_below_base", r, 32'h0);
    addr = STAT; #1; check_val("rdata_no_rd", rdata, 32'h0);

    // Single byte 0x55: fall latency and frame length
    send_byte(8'h55, 1'b1);
    @(negedge clk); check_val("tx_high_after_write_edge", {31'b0, tx}, 32'h1);
    @(negedge clk); check_val("tx_fall", {31'b0, tx}, 32'h0);
    c0 = cyc;
    wait_idle("single_idle", 400);
    check_val("frame_cycles", cyc - c0, 32'd160);
    bus_read(CON, r); check_val("con_done", r, 32'h2);
    bus_read(TXD, r); check_val("txd_last", r, 32'h55);
    check_val("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(STAT, 32'hFFFF_FFFF);
    bus_read(STAT, r); check_val("stat_write_ignored", r, 32'h4);
    bus_write(CON, 32'h2);
    bus_read(CON, r); check_val("con_cleared", r, 32'h0);

    // Burst of six: last one overflows
    nb = start_q.size();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i <= 5);
    bus_read(STAT, r); check_val("burst_stat", r, 32'h4B);
    bus_read(TXD, r);  check_val("burst_txd_last", r, 32'h05);
    wait_idle("burst_idle", 1200);
    @(negedge clk);
    check_val("burst_frames", start_q.size() - nb, 32'd5);
    for (int k = 1; k < 5 && nb + k < start_q.size(); k++)
      check_val("burst_gap", start_q[nb+k] - start_q[nb+k-1], 32'd160);
    bus_write(CON, 32'h2);
    bus_read(STAT, r); check_val("ovf_cleared", r, 32'h4);

    // Interrupt after the second of two queued frames
    bus_write(CON, 32'h1);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h3C, 1'b1);
    n = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (irq) begin n = i; break; end
    end
    check_val("irq_rise_cycle", n, 32'd321);
    bus_read(STAT, r); check_val("irq_stat_idle", r, 32'h4);
    bus_write(CON, 32'h3);
    @(negedge clk); check_val("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(CON, r); check_val("con_after_clear", r, 32'h1);

    // Count readback and push-on-pop into a full FIFO
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    bus_read(STAT, r); check_val("stat_cnt3_busy", r, 32'h31);
    send_byte(8'h55, 1'b1);
    repeat (156) @(posedge clk);
    #1;
    bus_read(STAT, r); check_val("stat_full_before_pop", r, 32'h43);
    send_byte(8'h66, 1'b1);
    bus_read(STAT, r); check_val("stat_push_on_pop", r, 32'h43);
    bus_read(TXD, r);  check_val("txd_push_on_pop", r, 32'h66);
    wait_idle("full_pop_idle", 1500);
    @(negedge clk);
    check_val("irq_after_frames", {31'b0, irq}, 32'h1);

    // Reset in the middle of a frame
    mon_en = 1'b0;
    send_byte(8'h00, 1'b0);
    repeat (40) @(posedge clk);
    #3;
    check_val("tx_low_mid_frame", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check_val("async_rst_tx", {31'b0, tx}, 32'h1);
    check_val("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(STAT, r); check_val("post_rst_stat", r, 32'h4);
    bus_read(CON, r);  check_val("post_rst_con", r, 32'h0);
    bus_read(TXD, r);  check_val("post_rst_txd", r, 32'h0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_val("post_rst_line_idle", lows, 32'd0);

    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    check_val("total_frames", frames, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
